// File: rtl/vga_fill_pkg.sv
// Shared constants, state encoding and pattern colour function for the VGA fill sequencer.
package vga_fill_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int XW       = 8;
  localparam int YW       = 7;
  localparam int CW       = 3;

  localparam logic [1:0] MODE_SOLID   = 2'd0;
  localparam logic [1:0] MODE_VSTRIPE = 2'd1;
  localparam logic [1:0] MODE_HSTRIPE = 2'd2;
  localparam logic [1:0] MODE_CHECK   = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [CW-1:0] pattern_colour(input logic [1:0]    sel,
                                                   input logic [CW-1:0] base,
                                                   input logic [XW-1:0] px,
                                                   input logic [YW-1:0] py);
    logic [CW-1:0] c;
    case (sel)
      MODE_SOLID:   c = base;
      MODE_VSTRIPE: c = px[2:0];
      MODE_HSTRIPE: c = py[2:0];
      MODE_CHECK:   c = (px[3] ^ py[3]) ? base : '0;
      default:      c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_fill_ctrl_if.sv
// Pixel-write port between the fill sequencer (master) and the VGA adapter/arbiter (slave).
interface vga_fill_ctrl_if;
  import vga_fill_pkg::*;

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [CW-1:0] colour;
  logic          plot;
  logic          plot_rdy;

  modport master (output x, y, colour, plot, input plot_rdy);
  modport slave  (input x, y, colour, plot, output plot_rdy);

endinterface

// File: rtl/vga_fill_ctrl_xy_scan_counter.sv
// Column-major frame scan counter: y is the inner index, x the outer; never wraps past the last pixel.
module xy_scan_counter
  import vga_fill_pkg::*;
(
  input  logic          CLOCK_50,
  input  logic          resetn,
  input  logic          clear,
  input  logic          advance,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last,
  output logic [XW-1:0] x_next,
  output logic [YW-1:0] y_next
);

  localparam logic [XW-1:0] X_MAX = XW'(SCREEN_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(SCREEN_H - 1);

  assign last = (x == X_MAX) && (y == Y_MAX);

  // next coordinates are exported so the colour can be registered alongside them
  always_comb begin
    x_next = x;
    y_next = y;
    if (clear) begin
      x_next = '0;
      y_next = '0;
    end else if (advance && !last) begin
      if (y == Y_MAX) begin
        y_next = '0;
        x_next = x + XW'(1);
      end else begin
        y_next = y + YW'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      x <= '0;
      y <= '0;
    end else begin
      x <= x_next;
      y <= y_next;
    end
  end

endmodule

// File: rtl/vga_fill_ctrl.sv
// Frame-fill sequencer: walks every pixel of the frame buffer once with a start/busy/done handshake.
//   state | meaning
//   IDLE  | waiting for start; x/y parked at 0
//   FILL  | plot asserted, one pixel per cycle with plot_rdy, stalls otherwise
//   DONE  | one-cycle done pulse after the last pixel
module vga_fill_ctrl
  import vga_fill_pkg::*;
(
  input  logic           CLOCK_50,
  input  logic           resetn,
  input  logic           start,
  input  logic [1:0]     mode,
  input  logic [CW-1:0]  colour_in,
  input  logic           abort,
  vga_fill_ctrl_if.master pix,
  output logic           busy,
  output logic           done
);

  state_t        state, state_n;
  logic [1:0]    mode_q, mode_sel;
  logic [CW-1:0] base_q, base_sel, colour_q;
  logic          plot_q, plot_n, busy_n, done_n;
  logic          clear, advance, latch;
  logic [XW-1:0] x_cnt, x_next;
  logic [YW-1:0] y_cnt, y_next;
  logic          last;

  xy_scan_counter u_scan (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .clear    (clear),
    .advance  (advance),
    .x        (x_cnt),
    .y        (y_cnt),
    .last     (last),
    .x_next   (x_next),
    .y_next   (y_next)
  );

  always_comb begin
    state_n = state;
    plot_n  = 1'b0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    clear   = 1'b0;
    advance = 1'b0;
    latch   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          latch   = 1'b1;
          clear   = 1'b1;
          plot_n  = 1'b1;
          busy_n  = 1'b1;
          state_n = FILL;
        end
      end
      FILL: begin
        plot_n = 1'b1;
        busy_n = 1'b1;
        if (abort) begin
          clear   = 1'b1;
          plot_n  = 1'b0;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else if (pix.plot_rdy) begin
          if (last) begin
            plot_n  = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = DONE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      DONE: begin
        clear   = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // the first pixel of a fill must already use the mode/colour being latched
  assign mode_sel = latch ? mode      : mode_q;
  assign base_sel = latch ? colour_in : base_q;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      mode_q   <= '0;
      base_q   <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      plot_q   <= plot_n;
      busy     <= busy_n;
      done     <= done_n;
      colour_q <= pattern_colour(mode_sel, base_sel, x_next, y_next);
      if (latch) begin
        mode_q <= mode;
        base_q <= colour_in;
      end
    end
  end

  assign pix.x      = x_cnt;
  assign pix.y      = y_cnt;
  assign pix.colour = colour_q;
  assign pix.plot   = plot_q;

endmodule
